// File: rtl/fifo_pkg.sv
// Shared pointer helpers and sizing constants for the programmable FIFO controller.
// Pointers carry one extra wrap bit above the RAM address bits.
package fifo_pkg;

  localparam int COUNT_EXTRA_BITS = 2;

  // Pointers are zero-extended to 32 bits by callers; only depthLog+1 bits are significant.
  function automatic logic ptr_full(input logic [31:0] wrPtr, input logic [31:0] rdPtr,
                                    input int depthLog);
    logic [31:0] occupancy;
    occupancy = (wrPtr - rdPtr) & ((32'd1 << (depthLog + 1)) - 32'd1);
    return occupancy == (32'd1 << depthLog);
  endfunction

  function automatic logic ptr_empty(input logic [31:0] rdPtr, input logic [31:0] wrPtr);
    return rdPtr == wrPtr;
  endfunction

endpackage

// File: rtl/fifo_fwft_buffer.sv
// Show-ahead output stage: head/skid register pair fed by a 1-cycle-latency RAM.
// Keeps buffered + in-flight words at most two, which sustains one word per cycle.
module fifo_fwft_buffer
#(
  parameter int WIDTH = 8
)
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ramNotEmpty,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_ramReadData,
  output logic             o_ramReadReq,
  output logic             o_headValid,
  output logic [WIDTH-1:0] o_headData
);

  logic [1:0]       r_bufCount;
  logic             r_inFlight;
  logic             r_headValid;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_skid;
  logic [2:0]       w_pending;
  logic [1:0]       w_bufNext;
  logic             w_ramReadReq;

  // A pop is only ever presented while the head is valid, so these never go negative.
  always_comb begin
    w_pending    = 3'(r_bufCount) + 3'(r_inFlight) - 3'(i_pop);
    w_ramReadReq = i_ramNotEmpty && (w_pending < 3'd2);
    w_bufNext    = r_bufCount + 2'(r_inFlight) - 2'(i_pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bufCount  <= 2'd0;
      r_inFlight  <= 1'b0;
      r_headValid <= 1'b0;
      r_head      <= '0;
      r_skid      <= '0;
    end else begin
      r_inFlight  <= w_ramReadReq;
      r_bufCount  <= w_bufNext;
      r_headValid <= (w_bufNext != 2'd0);
      case ({i_pop, r_inFlight})
        2'b11: begin
          if (r_bufCount == 2'd2) begin
            r_head <= r_skid;
            r_skid <= i_ramReadData;
          end else begin
            r_head <= i_ramReadData;
          end
        end
        2'b10: begin
          if (r_bufCount == 2'd2) r_head <= r_skid;
        end
        2'b01: begin
          if (r_bufCount == 2'd0) r_head <= i_ramReadData;
          else                    r_skid <= i_ramReadData;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_ramReadReq = w_ramReadReq;
  assign o_headValid  = r_headValid;
  assign o_headData   = r_head;

endmodule

// File: rtl/fifo_ctrl_prog.sv
// Synchronous FIFO controller for an external simple dual-port RAM with 1-cycle read latency.
// Tracks occupancy, programmable almost flags, sticky error flags, and optional show-ahead output.
module fifo_ctrl_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LOG = 8,
  parameter int AF_TH     = 2**DEPTH_LOG - 2,
  parameter int AE_TH     = 2,
  parameter int FWFT      = 0
)
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_fifo_write_req,
  input  logic [WIDTH-1:0]       i_fifo_write_data,
  output logic                   o_fifo_full,
  output logic                   o_fifo_almost_full,
  input  logic                   i_fifo_read_req,
  output logic [WIDTH-1:0]       o_fifo_read_data,
  output logic                   o_fifo_read_valid,
  output logic                   o_fifo_empty,
  output logic                   o_fifo_almost_empty,
  output logic [DEPTH_LOG+1:0]   o_fifo_count,
  output logic                   o_fifo_overflow,
  output logic                   o_fifo_underflow,
  input  logic                   i_err_clear,
  output logic                   o_ram_write_req,
  output logic [DEPTH_LOG-1:0]   o_ram_write_addr,
  output logic [WIDTH-1:0]       o_ram_write_data,
  output logic                   o_ram_read_req,
  output logic [DEPTH_LOG-1:0]   o_ram_read_addr,
  input  logic [WIDTH-1:0]       i_ram_read_data
);

  localparam int CW = DEPTH_LOG + COUNT_EXTRA_BITS;
  localparam int PW = DEPTH_LOG + 1;

  logic [PW-1:0]        r_wrPtr;
  logic [PW-1:0]        r_rdPtr;
  logic [PW-1:0]        r_wrCommit;
  logic [CW-1:0]        r_count;
  logic                 r_full;
  logic                 r_almostFull;
  logic                 r_almostEmpty;
  logic                 r_overflow;
  logic                 r_underflow;
  logic                 r_ramWriteReq;
  logic [DEPTH_LOG-1:0] r_ramWriteAddr;
  logic [WIDTH-1:0]     r_ramWriteData;

  logic [PW-1:0]        w_wrPtrNext;
  logic [PW-1:0]        w_rdPtrNext;
  logic [CW-1:0]        w_countNext;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_rdAdvance;
  logic                 w_empty;
  logic                 w_ramNotEmpty;
  logic                 w_readValid;
  logic [WIDTH-1:0]     w_readData;

  // The read side only sees words whose RAM write edge has passed (r_wrCommit lags r_wrPtr).
  assign w_push        = i_fifo_write_req && !r_full;
  assign w_ramNotEmpty = !ptr_empty(32'(r_rdPtr), 32'(r_wrCommit));
  assign w_wrPtrNext   = r_wrPtr + PW'(w_push);
  assign w_rdPtrNext   = r_rdPtr + PW'(w_rdAdvance);
  assign w_countNext   = r_count + CW'(w_push) - CW'(w_pop);

  generate
    if (FWFT != 0) begin : g_fwft
      logic             w_headValid;
      logic [WIDTH-1:0] w_headData;
      logic             w_issue;

      fifo_fwft_buffer #(.WIDTH(WIDTH)) u_fwftBuffer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_ramNotEmpty (w_ramNotEmpty),
        .i_pop         (w_pop),
        .i_ramReadData (i_ram_read_data),
        .o_ramReadReq  (w_issue),
        .o_headValid   (w_headValid),
        .o_headData    (w_headData)
      );

      assign w_pop       = i_fifo_read_req && w_headValid;
      assign w_rdAdvance = w_issue;
      assign w_empty     = !w_headValid;
      assign w_readValid = w_headValid;
      assign w_readData  = w_headData;
    end else begin : g_std
      logic r_readValid;
      logic r_emptyStd;

      assign w_pop       = i_fifo_read_req && !r_emptyStd;
      assign w_rdAdvance = w_pop;
      assign w_empty     = r_emptyStd;

      // Empty compares against next cycle's commit pointer, which is the current write pointer.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_readValid <= 1'b0;
          r_emptyStd  <= 1'b1;
        end else begin
          r_readValid <= w_pop;
          r_emptyStd  <= ptr_empty(32'(w_rdPtrNext), 32'(r_wrPtr));
        end
      end

      assign w_readValid = r_readValid;
      assign w_readData  = r_readValid ? i_ram_read_data : '0;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr        <= '0;
      r_rdPtr        <= '0;
      r_wrCommit     <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_almostFull   <= 1'b0;
      r_almostEmpty  <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
      r_ramWriteReq  <= 1'b0;
      r_ramWriteAddr <= '0;
      r_ramWriteData <= '0;
    end else begin
      r_wrPtr       <= w_wrPtrNext;
      r_rdPtr       <= w_rdPtrNext;
      r_wrCommit    <= r_wrPtr;
      r_count       <= w_countNext;
      r_full        <= ptr_full(32'(w_wrPtrNext), 32'(w_rdPtrNext), DEPTH_LOG);
      r_almostFull  <= (w_countNext >= CW'(AF_TH));
      r_almostEmpty <= (w_countNext <= CW'(AE_TH));
      r_ramWriteReq <= w_push;
      if (w_push) begin
        r_ramWriteAddr <= r_wrPtr[DEPTH_LOG-1:0];
        r_ramWriteData <= i_fifo_write_data;
      end
      // Setting a sticky flag takes priority over a same-cycle clear.
      if (i_fifo_write_req && r_full) r_overflow <= 1'b1;
      else if (i_err_clear)           r_overflow <= 1'b0;
      if (i_fifo_read_req && w_empty) r_underflow <= 1'b1;
      else if (i_err_clear)           r_underflow <= 1'b0;
    end
  end

  assign o_fifo_full         = r_full;
  assign o_fifo_almost_full  = r_almostFull;
  assign o_fifo_read_data    = w_readData;
  assign o_fifo_read_valid   = w_readValid;
  assign o_fifo_empty        = w_empty;
  assign o_fifo_almost_empty = r_almostEmpty;
  assign o_fifo_count        = r_count;
  assign o_fifo_overflow     = r_overflow;
  assign o_fifo_underflow    = r_underflow;
  assign o_ram_write_req     = r_ramWriteReq;
  assign o_ram_write_addr    = r_ramWriteAddr;
  assign o_ram_write_data    = r_ramWriteData;
  assign o_ram_read_req      = w_rdAdvance;
  assign o_ram_read_addr     = r_rdPtr[DEPTH_LOG-1:0];

endmodule

// File: tb/tb_fifo_ctrl_prog.sv
// Directed bench for fifo_ctrl_prog: one standard-read and one show-ahead instance on a 4-deep RAM.
// Both instances share stimulus; each has its own behavioural RAM with 1-cycle read latency.
module tb_fifo_ctrl_prog;

  logic       clk;
  logic       rst;
  logic       wrReq;
  logic [7:0] wrData;
  logic       rdReq;
  logic       errClear;

  logic       sFull, sAlmostFull, sReadValid, sEmpty, sAlmostEmpty, sOverflow, sUnderflow;
  logic [7:0] sReadData, sRamWd, sRamRd;
  logic [3:0] sCount;
  logic       sRamWe, sRamRe;
  logic [1:0] sRamWa, sRamRa;

  logic       fFull, fAlmostFull, fReadValid, fEmpty, fAlmostEmpty, fOverflow, fUnderflow;
  logic [7:0] fReadData, fRamWd, fRamRd;
  logic [3:0] fCount;
  logic       fRamWe, fRamRe;
  logic [1:0] fRamWa, fRamRa;

  logic [7:0] sMem [4];
  logic [7:0] fMem [4];

  int checkCount;
  int errorCount;

  fifo_ctrl_prog #(.WIDTH(8), .DEPTH_LOG(2), .AF_TH(3), .AE_TH(1), .FWFT(0)) dutStd (
    .i_clk(clk), .i_rst(rst),
    .i_fifo_write_req(wrReq), .i_fifo_write_data(wrData),
    .o_fifo_full(sFull), .o_fifo_almost_full(sAlmostFull),
    .i_fifo_read_req(rdReq), .o_fifo_read_data(sReadData), .o_fifo_read_valid(sReadValid),
    .o_fifo_empty(sEmpty), .o_fifo_almost_empty(sAlmostEmpty), .o_fifo_count(sCount),
    .o_fifo_overflow(sOverflow), .o_fifo_underflow(sUnderflow), .i_err_clear(errClear),
    .o_ram_write_req(sRamWe), .o_ram_write_addr(sRamWa), .o_ram_write_data(sRamWd),
    .o_ram_read_req(sRamRe), .o_ram_read_addr(sRamRa), .i_ram_read_data(sRamRd)
  );

  fifo_ctrl_prog #(.WIDTH(8), .DEPTH_LOG(2), .AF_TH(3), .AE_TH(1), .FWFT(1)) dutFwft (
    .i_clk(clk), .i_rst(rst),
    .i_fifo_write_req(wrReq), .i_fifo_write_data(wrData),
    .o_fifo_full(fFull), .o_fifo_almost_full(fAlmostFull),
    .i_fifo_read_req(rdReq), .o_fifo_read_data(fReadData), .o_fifo_read_valid(fReadValid),
    .o_fifo_empty(fEmpty), .o_fifo_almost_empty(fAlmostEmpty), .o_fifo_count(fCount),
    .o_fifo_overflow(fOverflow), .o_fifo_underflow(fUnderflow), .i_err_clear(errClear),
    .o_ram_write_req(fRamWe), .o_ram_write_addr(fRamWa), .o_ram_write_data(fRamWd),
    .o_ram_read_req(fRamRe), .o_ram_read_addr(fRamRa), .i_ram_read_data(fRamRd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sRamWe) sMem[sRamWa] <= sRamWd;
    if (sRamRe) sRamRd <= sMem[sRamRa];
    if (fRamWe) fMem[fRamWa] <= fRamWd;
    if (fRamRe) fRamRd <= fMem[fRamRa];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change at the falling edge; outputs are inspected at the next falling edge.
  task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic rd, input logic clr);
    wrReq    = wr;
    wrData   = data;
    rdReq    = rd;
    errClear = clr;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] fillData [4];
    logic [7:0] pairData [5];
    int         lat;

    checkCount = 0;
    errorCount = 0;
    fillData   = '{8'h11, 8'h22, 8'h33, 8'h44};
    pairData   = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hB2};

    rst = 1'b1;
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rst_empty", sEmpty, 1);
    checkOutput("rst_aempty", sAlmostEmpty, 1);
    checkOutput("rst_count", sCount, 0);
    checkOutput("rst_full", sFull, 0);
    checkOutput("rst_afull", sAlmostFull, 0);
    checkOutput("rst_valid", sReadValid, 0);
    checkOutput("rst_rdata", sReadData, 0);
    checkOutput("rst_sticky", {sOverflow, sUnderflow}, 0);
    checkOutput("rst_ram_we", sRamWe, 0);
    checkOutput("rst_ram_re", sRamRe, 0);
    checkOutput("rst_fwft_empty", fEmpty, 1);
    checkOutput("rst_fwft_valid", fReadValid, 0);
    rst = 1'b0;

    $display("[TB] fill to full and overflow");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fillData[i], 1'b0, 1'b0);
      checkOutput("fill_count", sCount, 32'(i + 1));
      checkOutput("fill_ram_we", sRamWe, 1);
      checkOutput("fill_ram_wa", sRamWa, 32'(i));
      checkOutput("fill_ram_wd", sRamWd, fillData[i]);
      checkOutput("fill_afull", sAlmostFull, 32'(i >= 2));
      checkOutput("fill_full", sFull, 32'(i == 3));
      checkOutput("fill_aempty", sAlmostEmpty, 32'(i == 0));
    end
    checkOutput("fill_readable", sEmpty, 0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("ovf_no_write", sRamWe, 0);
    checkOutput("ovf_flag", sOverflow, 1);
    checkOutput("ovf_count", sCount, 4);
    checkOutput("ovf_full", sFull, 1);

    $display("[TB] standard drain and underflow");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_valid", sReadValid, 1);
      checkOutput("drain_data", sReadData, fillData[i]);
      checkOutput("drain_count", sCount, 32'(3 - i));
      checkOutput("drain_full", sFull, 0);
      checkOutput("drain_afull", sAlmostFull, 32'(i == 0));
    end
    checkOutput("drain_empty", sEmpty, 1);
    checkOutput("drain_aempty", sAlmostEmpty, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("udf_no_valid", sReadValid, 0);
    checkOutput("udf_flag", sUnderflow, 1);
    checkOutput("udf_ovf_sticky", sOverflow, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("clr_udf", sUnderflow, 0);
    checkOutput("clr_ovf", sOverflow, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("set_beats_clr", sUnderflow, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("clr_again", sUnderflow, 0);

    $display("[TB] pointer wrap with push/pop pairs");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      checkOutput("wrap_ram_wa", sRamWa, 32'(i % 4));
      checkOutput("wrap_count_push", sCount, 1);
      checkOutput("wrap_commit_lag", sEmpty, 1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("wrap_readable", sEmpty, 0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("wrap_valid", sReadValid, 1);
      checkOutput("wrap_data", sReadData, 32'(i));
      checkOutput("wrap_count_pop", sCount, 0);
    end

    $display("[TB] simultaneous push and pop at count 2");
    applyStimulus(1'b1, 8'hA0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
    checkOutput("pair_start_count", sCount, 2);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 8'(8'hB0 + k), 1'b1, 1'b0);
      checkOutput("pair_count", sCount, 2);
      checkOutput("pair_flags", {sFull, sAlmostFull, sAlmostEmpty, sEmpty}, 0);
      checkOutput("pair_valid", sReadValid, 1);
      checkOutput("pair_data", sReadData, pairData[k]);
      checkOutput("pair_sticky", {sOverflow, sUnderflow}, 0);
    end

    $display("[TB] reset mid-operation, then show-ahead mode");
    rst = 1'b1;
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("midrst_count", sCount, 0);
    checkOutput("midrst_empty", sEmpty, 1);
    checkOutput("midrst_fwft_count", fCount, 0);
    checkOutput("midrst_fwft_valid", fReadValid, 0);

    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    lat = 0;
    while (!fReadValid && lat < 10) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      lat++;
    end
    checkOutput("fwft_latency", 32'(lat), 3);
    checkOutput("fwft_head_valid", fReadValid, 1);
    checkOutput("fwft_head_data", fReadData, 8'hA5);
    checkOutput("fwft_head_empty", fEmpty, 0);
    checkOutput("fwft_head_count", fCount, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("fwft_pop_valid", fReadValid, 0);
    checkOutput("fwft_pop_empty", fEmpty, 1);
    checkOutput("fwft_pop_count", fCount, 0);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("fwft_fill_count", fCount, 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("fwft_stream_valid", fReadValid, 1);
      checkOutput("fwft_stream_data", fReadData, 32'(8'hC0 + k));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("fwft_end_valid", fReadValid, 0);
    checkOutput("fwft_end_empty", fEmpty, 1);
    checkOutput("fwft_end_count", fCount, 0);
    checkOutput("fwft_end_udf", fUnderflow, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
